mem_access_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execute stage of the RISC-V Lite core. Holds the EX/MEM pipeline register and resolves branch/jump redirection from the execute results. Performs loads and stores over a req/gnt/rvalid data-memory handshake and produces the MEM/WB register consumed by write-back. Stalls the upstream pipeline while a data-memory access is outstanding.

---
 rtl/mem_access_stage_if.sv | 58 +++++
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: execute-side inputs, forwarding/redirect outputs, data-memory bus and MEM/WB outputs.
// The slave modport is the stage's view; the master modport is the surrounding pipeline and memory.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              ex_valid;
    logic [31:0]       ex_alu_result;
    logic [31:0]       ex_store_data;
    logic [31:0]       ex_pc_jump;
    logic              ex_bit_branch;
    logic              ex_branch;
    logic              ex_jump;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic [2:0]        ex_funct3;
    logic [4:0]        ex_rd;
    logic              mem_stall;
    logic              pc_src;
    logic [31:0]       pc_target;
    logic [31:0]       mem_alu_result;
    logic [4:0]        mem_rd;
    logic              mem_reg_write;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [31:0]       dmem_rdata;
    logic              wb_valid;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_alu_result;
    logic [31:0]       wb_load_data;
    logic              mem_misalign;

    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data, ex_pc_jump, ex_bit_branch, ex_branch, ex_jump,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_funct3, ex_rd,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        output mem_stall, pc_src, pc_target, mem_alu_result, mem_rd, mem_reg_write,
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_load_data, mem_misalign
    );

    modport master (
        output ex_valid, ex_alu_result, ex_store_data, ex_pc_jump, ex_bit_branch, ex_branch, ex_jump,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_funct3, ex_rd,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        input  mem_stall, pc_src, pc_target, mem_alu_result, mem_rd, mem_reg_write,
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_load_data, mem_misalign
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM register, branch redirect, req/gnt/rvalid load-store FSM and MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    input logic               en_i,
    mem_access_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_e;

    state_e      state_q;
    logic        valid_q;
    logic        bit_branch_q;
    logic        branch_q;
    logic        jump_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic [31:0] alu_q;
    logic [31:0] store_data_q;
    logic [31:0] pc_jump_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        wb_valid_q;
    logic        wb_reg_write_q;
    logic        wb_mem_to_reg_q;
    logic        misalign_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_alu_q;
    logic [31:0] wb_load_q;

    logic [1:0]  lane;
    logic        misaligned;
    logic        mem_op;
    logic        req;
    logic        st_done;
    logic        rd_done;
    logic        stall;
    logic        complete;
    logic        pc_src;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = valid_q & (mem_read_q | mem_write_q) &
                        ((funct3_q[1:0] == 2'b01 & alu_q[0]) | (funct3_q[1:0] == 2'b10 & alu_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        lane     = alu_q[1:0];
        mem_op   = valid_q & (mem_read_q | mem_write_q) & ~misaligned;
        req      = mem_op & (state_q != WAIT_RD);
        // a frozen pipeline must not consume a grant or read response
        st_done  = en_i & req & bus.dmem_gnt & mem_write_q;
        rd_done  = en_i & (state_q == WAIT_RD) & bus.dmem_rvalid;
        stall    = mem_op & ~(st_done | rd_done);
        complete = valid_q & ~stall;
        pc_src   = valid_q & ((branch_q & bit_branch_q) | jump_q);
        be_d     = funct3_q[1:0] == 2'b00 ? 4'b0001 << lane :
                   funct3_q[1:0] == 2'b01 ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
        wdata_d  = funct3_q[1:0] == 2'b00 ? {4{store_data_q[7:0]}} :
                   funct3_q[1:0] == 2'b01 ? {2{store_data_q[15:0]}} : store_data_q;
        rbyte    = lane == 2'd0 ? bus.dmem_rdata[7:0] :
                   lane == 2'd1 ? bus.dmem_rdata[15:8] :
                   lane == 2'd2 ? bus.dmem_rdata[23:16] : bus.dmem_rdata[31:24];
        rhalf    = lane[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        load_d   = funct3_q == 3'b000 ? {{24{rbyte[7]}}, rbyte} :
                   funct3_q == 3'b001 ? {{16{rhalf[15]}}, rhalf} :
                   funct3_q == 3'b100 ? {24'd0, rbyte} :
                   funct3_q == 3'b101 ? {16'd0, rhalf} : bus.dmem_rdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (en_i) begin
            case (state_q)
                IDLE, REQ: state_q <= !mem_op ? IDLE : !bus.dmem_gnt ? REQ : mem_write_q ? IDLE : WAIT_RD;
                WAIT_RD:   state_q <= bus.dmem_rvalid ? IDLE : WAIT_RD;
                default:   state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= 1'b0;
            bit_branch_q <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_q        <= '0;
            store_data_q <= '0;
            pc_jump_q    <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
        end else if (en_i && !stall) begin
            // the instruction behind a taken branch/jump enters as a bubble
            valid_q      <= bus.ex_valid & ~pc_src;
            bit_branch_q <= bus.ex_bit_branch;
            branch_q     <= bus.ex_branch;
            jump_q       <= bus.ex_jump;
            mem_read_q   <= bus.ex_mem_read;
            mem_write_q  <= bus.ex_mem_write;
            reg_write_q  <= bus.ex_reg_write;
            mem_to_reg_q <= bus.ex_mem_to_reg;
            alu_q        <= bus.ex_alu_result;
            store_data_q <= bus.ex_store_data;
            pc_jump_q    <= bus.ex_pc_jump;
            funct3_q     <= bus.ex_funct3;
            rd_q         <= bus.ex_rd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            misalign_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_alu_q        <= '0;
            wb_load_q       <= '0;
        end else if (en_i) begin
            wb_valid_q <= complete;
            misalign_q <= complete & misaligned;
            if (complete) begin
                wb_reg_write_q  <= reg_write_q & ~mem_write_q & ~misaligned;
                wb_mem_to_reg_q <= mem_to_reg_q;
                wb_rd_q         <= rd_q;
                wb_alu_q        <= alu_q;
            end
            if (rd_done)
                wb_load_q <= load_d;
        end
    end

    assign bus.mem_stall      = stall;
    assign bus.pc_src         = pc_src;
    assign bus.pc_target      = pc_jump_q;
    assign bus.mem_alu_result = alu_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_reg_write  = valid_q & reg_write_q;
    assign bus.dmem_req       = req;
    assign bus.dmem_we        = req & mem_write_q;
    assign bus.dmem_addr      = {alu_q[ADDR_W-1:2], 2'b00};
    assign bus.dmem_be        = be_d;
    assign bus.dmem_wdata     = wdata_d;
    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_reg_write   = wb_reg_write_q;
    assign bus.wb_mem_to_reg  = wb_mem_to_reg_q;
    assign bus.wb_rd          = wb_rd_q;
    assign bus.wb_alu_result  = wb_alu_q;
    assign bus.wb_load_data   = wb_load_q;
    assign bus.mem_misalign   = misalign_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed steps with a write-back scoreboard for mem_access_stage.
// Expectations follow MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_access_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    mem_access_stage_if #(.ADDR_W(32)) bus ();
    mem_access_stage #(.ADDR_W(32)) dut (.clk_i(clk), .rst_ni(rst_n), .en_i(en), .bus(bus));

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        rw;
        logic        m2r;
        logic        chk_ld;
    } wb_t;

    wb_t sb[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] ld,
                        input logic rw, input logic m2r, input logic c);
        wb_t e;
        e.rd = rd; e.alu = alu; e.ld = ld; e.rw = rw; e.m2r = m2r; e.chk_ld = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        wb_t e;
        if (rst_n && bus.wb_valid) begin
            chk("wb_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_rd", bus.wb_rd, e.rd);
                chk("wb_alu", bus.wb_alu_result, e.alu);
                chk("wb_reg_write", bus.wb_reg_write, e.rw);
                chk("wb_mem_to_reg", bus.wb_mem_to_reg, e.m2r);
                if (e.chk_ld) chk("wb_load", bus.wb_load_data, e.ld);
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pcj,
                         input logic bb, input logic br, input logic jp, input logic mr, input logic mw,
                         input logic rw, input logic m2r, input logic [2:0] f3, input logic [4:0] rd);
        bus.ex_valid = 1'b1; bus.ex_alu_result = alu; bus.ex_store_data = sd; bus.ex_pc_jump = pcj;
        bus.ex_bit_branch = bb; bus.ex_branch = br; bus.ex_jump = jp; bus.ex_mem_read = mr;
        bus.ex_mem_write = mw; bus.ex_reg_write = rw; bus.ex_mem_to_reg = m2r; bus.ex_funct3 = f3; bus.ex_rd = rd;
    endtask

    // gw: cycles before gnt; rl: cycles from gnt to rvalid (>=1)
    task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                        input logic [31:0] exp, input logic [3:0] be, input int gw, input int rl);
        int st = 0;
        tick; drive(addr, 0, 0, 0, 0, 0, 1, 0, 1, 1, f3, 5'd7); push(5'd7, addr, exp, 1, 1, 1);
        tick; bus.ex_valid = 1'b0;
        for (int c = 0; c < gw; c++) begin
            bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h5A5A_5A5A;
            smp; st += int'(bus.mem_stall); chk({tag, "_req_wait"}, bus.dmem_req, 1);
            tick;
        end
        bus.dmem_rvalid = 1'b0; bus.dmem_gnt = 1'b1;
        smp; st += int'(bus.mem_stall);
        chk({tag, "_req"}, bus.dmem_req, 1);
        chk({tag, "_we"}, bus.dmem_we, 0);
        chk({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, bus.dmem_be, be);
        tick; bus.dmem_gnt = 1'b0;
        for (int c = 1; c < rl; c++) begin
            smp; st += int'(bus.mem_stall); chk({tag, "_req_drop"}, bus.dmem_req, 0);
            tick;
        end
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdata;
        smp; st += int'(bus.mem_stall);
        tick; bus.dmem_rvalid = 1'b0;
        smp;
        chk({tag, "_wb_valid"}, bus.wb_valid, 1);
        chk({tag, "_load"}, bus.wb_load_data, exp);
        chk({tag, "_misalign"}, bus.mem_misalign, 0);
        chk({tag, "_stall_cycles"}, 32'(st), 32'(gw + rl));
        tick; smp; chk({tag, "_wb_bubble"}, bus.wb_valid, 0);
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data,
                         input logic [3:0] be, input logic [31:0] wd, input int gw);
        int st = 0;
        tick; drive(addr, data, 0, 0, 0, 0, 0, 1, 1, 0, f3, 5'd3); push(5'd3, addr, 0, 0, 0, 0);
        tick; bus.ex_valid = 1'b0;
        for (int c = 0; c < gw; c++) begin
            smp; st += int'(bus.mem_stall); chk({tag, "_req_wait"}, bus.dmem_req, 1);
            tick;
        end
        bus.dmem_gnt = 1'b1;
        smp; st += int'(bus.mem_stall);
        chk({tag, "_req"}, bus.dmem_req, 1);
        chk({tag, "_we"}, bus.dmem_we, 1);
        chk({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, bus.dmem_be, be);
        chk({tag, "_wdata"}, bus.dmem_wdata, wd);
        tick; bus.dmem_gnt = 1'b0;
        smp;
        chk({tag, "_wb_valid"}, bus.wb_valid, 1);
        chk({tag, "_wb_reg_write"}, bus.wb_reg_write, 0);
        chk({tag, "_req_idle"}, bus.dmem_req, 0);
        chk({tag, "_stall_cycles"}, 32'(st), 32'(gw));
    endtask

    initial begin
        bus.ex_valid = 0; bus.ex_alu_result = 0; bus.ex_store_data = 0; bus.ex_pc_jump = 0;
        bus.ex_bit_branch = 0; bus.ex_branch = 0; bus.ex_jump = 0; bus.ex_mem_read = 0; bus.ex_mem_write = 0;
        bus.ex_reg_write = 0; bus.ex_mem_to_reg = 0; bus.ex_funct3 = 0; bus.ex_rd = 0;
        bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
        smp;
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_stall", bus.mem_stall, 0);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_pc_src", bus.pc_src, 0);
        chk("rst_addr", bus.dmem_addr, 0);
        chk("rst_misalign", bus.mem_misalign, 0);
        tick; rst_n = 1'b1; en = 1'b1;

        // ADD: result on write-back one cycle after capture, never stalls
        tick; drive(32'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 5'd5); push(5'd5, 32'h10, 0, 1, 0, 0);
        tick; bus.ex_valid = 1'b0;
        smp;
        chk("add_stall", bus.mem_stall, 0);
        chk("add_fwd_alu", bus.mem_alu_result, 32'h10);
        chk("add_fwd_rd", bus.mem_rd, 5);
        tick; smp;
        chk("add_wb_valid", bus.wb_valid, 1);
        chk("add_wb_alu", bus.wb_alu_result, 32'h10);
        chk("add_stall_wb", bus.mem_stall, 0);
        tick; smp; chk("add_bubble", bus.wb_valid, 0);

        store("sb", 32'h103, 3'b000, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 0);
        store("sh", 32'h202, 3'b001, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 1);
        store("sw", 32'h300, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 0);

        load("lb", 32'h102, 3'b000, 32'h0080_0000, 32'hFFFF_FF80, 4'b0100, 0, 1);
        load("lbu", 32'h102, 3'b100, 32'h0080_0000, 32'h0000_0080, 4'b0100, 0, 1);
        load("lh", 32'h102, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001, 4'b1100, 0, 1);
        load("lhu", 32'h100, 3'b101, 32'h1234_ABCD, 32'h0000_ABCD, 4'b0011, 1, 2);
        load("lw", 32'h204, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 2, 3);

`ifdef MEM_MISALIGN_TRAP_EN
        tick; drive(32'h101, 0, 0, 0, 0, 0, 1, 0, 1, 1, 3'b001, 5'd7); push(5'd7, 32'h101, 0, 0, 1, 0);
        tick; bus.ex_valid = 1'b0;
        smp;
        chk("mis_no_req", bus.dmem_req, 0);
        chk("mis_no_stall", bus.mem_stall, 0);
        tick; smp;
        chk("mis_pulse", bus.mem_misalign, 1);
        chk("mis_wb_valid", bus.wb_valid, 1);
        chk("mis_wb_rw", bus.wb_reg_write, 0);
        tick; smp; chk("mis_pulse_end", bus.mem_misalign, 0);
`else
        load("lh_mis", 32'h101, 3'b001, 32'hAAAA_5555, 32'h0000_5555, 4'b0011, 0, 1);
`endif

        // taken branch redirects for one cycle and flushes the following instruction
        tick; drive(0, 0, 32'h200, 1, 1, 0, 0, 0, 0, 0, 3'b000, 5'd0); push(5'd0, 0, 0, 0, 0, 0);
        tick; drive(32'h99, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 5'd9);
        smp;
        chk("beq_pc_src", bus.pc_src, 1);
        chk("beq_target", bus.pc_target, 32'h200);
        tick; bus.ex_valid = 1'b0;
        smp;
        chk("beq_pc_src_end", bus.pc_src, 0);
        chk("beq_wb_valid", bus.wb_valid, 1);
        tick; smp; chk("beq_flushed", bus.wb_valid, 0);

        tick; drive(0, 0, 32'h300, 0, 1, 0, 0, 0, 0, 0, 3'b000, 5'd0); push(5'd0, 0, 0, 0, 0, 0);
        tick; bus.ex_valid = 1'b0;
        smp; chk("bne_not_taken", bus.pc_src, 0);
        tick; drive(0, 0, 32'h480, 0, 0, 1, 0, 0, 1, 0, 3'b000, 5'd1); push(5'd1, 0, 0, 1, 0, 0);
        tick; bus.ex_valid = 1'b0;
        smp;
        chk("jal_pc_src", bus.pc_src, 1);
        chk("jal_target", bus.pc_target, 32'h480);
        tick; tick;

        // EN low: grant ignored, request held
        tick; drive(32'h500, 0, 0, 0, 0, 0, 1, 0, 1, 1, 3'b010, 5'd7); push(5'd7, 32'h500, 32'h1122_3344, 1, 1, 1);
        tick; bus.ex_valid = 1'b0; en = 1'b0; bus.dmem_gnt = 1'b1;
        smp; chk("en_req", bus.dmem_req, 1);
        tick; smp;
        chk("en_req_held", bus.dmem_req, 1);
        chk("en_stall_held", bus.mem_stall, 1);
        chk("en_no_wb", bus.wb_valid, 0);
        tick; en = 1'b1;
        smp;
        tick; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1122_3344;
        smp; chk("en_rd_done", bus.mem_stall, 0);
        tick; bus.dmem_rvalid = 1'b0;
        smp;
        chk("en_wb_valid", bus.wb_valid, 1);
        chk("en_wb_load", bus.wb_load_data, 32'h1122_3344);
        tick;

        // reset while waiting for read data
        tick; drive(32'h400, 0, 0, 0, 0, 0, 1, 0, 1, 1, 3'b010, 5'd7);
        tick; bus.ex_valid = 1'b0; bus.dmem_gnt = 1'b1;
        smp; chk("rstmid_req", bus.dmem_req, 1);
        tick; bus.dmem_gnt = 1'b0;
        smp; chk("rstmid_wait_stall", bus.mem_stall, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_stall", bus.mem_stall, 0);
        chk("rstmid_req", bus.dmem_req, 0);
        chk("rstmid_alu", bus.mem_alu_result, 0);
        chk("rstmid_rd", bus.mem_rd, 0);
        chk("rstmid_wb_alu", bus.wb_alu_result, 0);
        tick; rst_n = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
        smp; chk("late_rvalid_req", bus.dmem_req, 0);
        tick; bus.dmem_rvalid = 1'b0;
        smp;
        chk("late_rvalid_wb", bus.wb_valid, 0);
        chk("late_rvalid_load", bus.wb_load_data, 0);

        tick; smp;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
